serial_adder: RTL

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop process the
// operands LSB-first, one bit per clock, behind a valid/ready handshake on each side.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // One spare bit keeps the counter from wrapping when WIDTH is a power of two.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_sub;
  logic [CW-1:0]    r_count;
  logic             r_inReady;
  logic             r_outValid;

  logic w_a;
  logic w_b;
  logic w_s;
  logic w_c;
  logic w_lastBit;

  // Subtraction is A + ~B + 1: B is inverted bit by bit and the carry is seeded with 1.
  assign w_a       = r_opA[0];
  assign w_b       = r_opB[0] ^ r_sub;
  assign w_s       = w_a ^ w_b ^ r_carry;
  assign w_c       = (w_a & w_b) | (r_carry & (w_a ^ w_b));
  assign w_lastBit = (r_count == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
      r_sub      <= 1'b0;
      r_count    <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA      <= A;
            r_opB      <= B;
            r_sub      <= sub;
            r_carry    <= sub ? 1'b1 : cin;
            r_count    <= '0;
            r_inReady  <= 1'b0;
            r_outValid <= 1'b0;
            r_state    <= RUN;
          end
        end

        RUN: begin
          // Result bits enter at the MSB so the first bit computed ends up at bit 0.
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_opA   <= r_opA >> 1;
          r_opB   <= r_opB >> 1;
          r_count <= r_count + CW'(1);
          if (w_lastBit) begin
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end
        end

        DONE: begin
          // Returning to IDLE with in_ready low means no operand is taken on this edge.
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign sum       = r_sum;
  assign carry     = r_carry;

endmodule
